// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss handler placed in front of one cache (instruction or data). When the
// cache reports a miss, the handler latches the block base address, issues
// WORDS pipelined reads to main memory on consecutive cycles, and writes each
// returned word into the cache data array. The last returned word also writes
// the tag array. While a fill is in progress the pipeline is stalled.
//
// Ports
//   clk                  in   1   system clock, rising edge
//   rst_n                in   1   asynchronous reset, active low
//   i_miss_detected      in   1   cache reports a miss on i_miss_address
//   i_miss_address       in  16   byte address that missed
//   i_memory_data        in  16   main-memory read data
//   i_memory_data_valid  in   1   i_memory_data answers the oldest outstanding read
//   o_fsm_busy           out  1   fill in progress, pipeline must stall
//   o_memory_enable      out  1   issue a read this cycle
//   o_memory_address     out 16   read address (0 when o_memory_enable=0)
//   o_write_data_array   out  1   write o_fill_data to the word at o_fill_addr
//   o_write_tag_array    out  1   write tag/valid for the block at o_fill_addr
//   o_fill_addr          out 16   byte address of the word being filled
//   o_fill_data          out 16   word being written (always i_memory_data)
//   o_dbg_state          out  1   current FSM state (0 = IDLE, 1 = FILL)
//
// Handshake: there is no back-pressure on either side. A read is issued in
// every cycle o_memory_enable=1, and every i_memory_data_valid beat seen in
// FILL is consumed in that same cycle (the fill side is always ready).
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int WORDS       = 8,
  parameter int OFFSET_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss_detected,
  input  logic [15:0] i_miss_address,
  input  logic [15:0] i_memory_data,
  input  logic        i_memory_data_valid,
  output logic        o_fsm_busy,
  output logic        o_memory_enable,
  output logic [15:0] o_memory_address,
  output logic        o_write_data_array,
  output logic        o_write_tag_array,
  output logic [15:0] o_fill_addr,
  output logic [15:0] o_fill_data,
  output logic        o_dbg_state
);

  localparam int              CNT_W       = (WORDS > 1) ? $clog2(WORDS) : 1;
  // The issue counter needs one extra bit so it can hold WORDS (all issued).
  localparam logic [CNT_W:0]  ISSUE_LIMIT = (CNT_W + 1)'(WORDS);
  localparam logic [CNT_W-1:0] RET_LAST   = CNT_W'(WORDS - 1);
  localparam logic [15:0]     OFFSET_MASK = 16'((1 << OFFSET_BITS) - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t           r_state;
  logic [15:0]      r_base;
  logic [CNT_W:0]   r_issue_cnt;
  logic [CNT_W-1:0] r_ret_cnt;

  logic        w_in_fill;
  logic        w_issue_pending;
  logic        w_beat;
  logic        w_last_beat;
  logic [15:0] w_issue_addr;
  logic [15:0] w_ret_addr;

  assign w_in_fill       = (r_state == ST_FILL);
  assign w_issue_pending = w_in_fill && (r_issue_cnt < ISSUE_LIMIT);
  // Return beats are only meaningful in FILL; stray valids in IDLE are dropped.
  assign w_beat          = w_in_fill && i_memory_data_valid;
  assign w_last_beat     = w_beat && (r_ret_cnt == RET_LAST);

  // The base has its offset bits cleared, so base + 2*cnt never leaves the block.
  assign w_issue_addr = r_base + (16'(r_issue_cnt) << 1);
  assign w_ret_addr   = r_base + (16'(r_ret_cnt) << 1);

  // Outputs are decoded from registered state plus the current-cycle inputs:
  // the stall must be visible in the miss cycle and the data write must
  // coincide with the memory beat, so these cannot be delayed a cycle.
  // The stall is gated by rst_n so a miss held during reset does not stall.
  assign o_fsm_busy         = rst_n & (w_in_fill | i_miss_detected);
  assign o_memory_enable    = w_issue_pending;
  assign o_memory_address   = w_issue_pending ? w_issue_addr : 16'h0000;
  assign o_write_data_array = w_beat;
  assign o_write_tag_array  = w_last_beat;
  assign o_fill_addr        = w_in_fill ? w_ret_addr : 16'h0000;
  assign o_fill_data        = i_memory_data;
  assign o_dbg_state        = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_base      <= 16'h0000;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_miss_detected) begin
            r_base      <= i_miss_address & ~OFFSET_MASK;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Issue and return run independently; returns may overlap issues.
          if (w_issue_pending) begin
            r_issue_cnt <= r_issue_cnt + (CNT_W + 1)'(1);
          end
          if (i_memory_data_valid) begin
            r_ret_cnt <= r_ret_cnt + CNT_W'(1);
            if (r_ret_cnt == RET_LAST) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
